// File: rtl/taxi_eth_pkg.sv
// Shared Ethernet constants and the destination-filter state encoding.
package taxi_eth_pkg;

    localparam int          ETH_ALEN       = 6;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
    localparam int          ETH_MCAST_BIT  = 40;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        REPLAY = 2'd1,
        PASS   = 2'd2,
        DROP   = 2'd3
    } filt_state_t;

endpackage

// File: rtl/taxi_axis_if.sv
// Minimal AXI-stream bundle; src drives data, snk drives tready.
interface taxi_axis_if #(
    parameter int DATA_W = 8,
    parameter int USER_W = 1
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tvalid, tlast, tuser, input  tready);
    modport snk (input  tdata, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/taxi_eth_addr_match.sv
// Combinational accept decision for a destination MAC against station config.
module taxi_eth_addr_match
    import taxi_eth_pkg::*;
(
    input  logic [47:0] i_addr,
    input  logic [47:0] i_mac_addr,
    input  logic        i_enable,
    input  logic        i_promisc,
    input  logic        i_bcast_en,
    input  logic        i_mcast_en,
    output logic        o_accept
);

    logic w_bcast;
    logic w_mcast;

    assign w_bcast = (i_addr == ETH_BCAST_ADDR);
    // Broadcast also has the group bit set; keep it out of the multicast class.
    assign w_mcast = i_addr[ETH_MCAST_BIT] & ~w_bcast;

    assign o_accept = i_enable & (i_promisc
                                | (i_addr == i_mac_addr)
                                | (i_bcast_en & w_bcast)
                                | (i_mcast_en & w_mcast));

endmodule

// File: rtl/taxi_eth_rx_dst_filter.sv
// Holds the 6-byte destination header, decides accept/drop, then replays the
// header and streams the remainder, or swallows the whole frame.
module taxi_eth_rx_dst_filter
    import taxi_eth_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int USER_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    input  logic             cfg_enable,
    input  logic [47:0]      cfg_mac_addr,
    input  logic             cfg_promisc,
    input  logic             cfg_bcast_en,
    input  logic             cfg_mcast_en,
    output logic             stat_accept,
    output logic             stat_drop,
    output logic             stat_runt,
    output logic [CNT_W-1:0] cnt_accept,
    output logic [CNT_W-1:0] cnt_drop
);

    filt_state_t       r_state, w_state_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        r_ridx;
    logic [7:0]        r_hdr_data [ETH_ALEN];
    logic [USER_W-1:0] r_hdr_user [ETH_ALEN];
    logic              r_last6;

    logic              r_cfg_enable, r_cfg_promisc, r_cfg_bcast_en, r_cfg_mcast_en;
    logic [47:0]       r_cfg_mac_addr;

    logic              w_hdr_beat, w_runt, w_eval, w_accept, w_reject, w_rep_done;
    logic [47:0]       w_addr;

    assign w_hdr_beat = (r_state == HDR) & s_axis.tvalid;
    assign w_runt     = w_hdr_beat & s_axis.tlast & (r_idx != 3'd5);
    assign w_eval     = w_hdr_beat & (r_idx == 3'd5);
    assign w_reject   = w_eval & ~w_accept;
    assign w_rep_done = (r_state == REPLAY) & m_axis.tready & (r_ridx == 3'd5);

    assign w_addr = {r_hdr_data[0], r_hdr_data[1], r_hdr_data[2],
                     r_hdr_data[3], r_hdr_data[4], s_axis.tdata};

    taxi_eth_addr_match u_match (
        .i_addr     (w_addr),
        .i_mac_addr (r_cfg_mac_addr),
        .i_enable   (r_cfg_enable),
        .i_promisc  (r_cfg_promisc),
        .i_bcast_en (r_cfg_bcast_en),
        .i_mcast_en (r_cfg_mcast_en),
        .o_accept   (w_accept)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= HDR;
            r_idx          <= 3'd0;
            r_ridx         <= 3'd0;
            r_last6        <= 1'b0;
            r_cfg_enable   <= 1'b0;
            r_cfg_promisc  <= 1'b0;
            r_cfg_bcast_en <= 1'b0;
            r_cfg_mcast_en <= 1'b0;
            r_cfg_mac_addr <= '0;
            stat_accept    <= 1'b0;
            stat_drop      <= 1'b0;
            stat_runt      <= 1'b0;
            cnt_accept     <= '0;
            cnt_drop       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            stat_accept <= w_rep_done;
            stat_drop   <= w_reject;
            stat_runt   <= w_runt;
            if (w_hdr_beat) begin
                r_hdr_data[r_idx] <= s_axis.tdata;
                r_hdr_user[r_idx] <= s_axis.tuser;
                // Config is frozen at byte 0 so a frame is judged by one setting.
                if (r_idx == 3'd0) begin
                    r_cfg_enable   <= cfg_enable;
                    r_cfg_promisc  <= cfg_promisc;
                    r_cfg_bcast_en <= cfg_bcast_en;
                    r_cfg_mcast_en <= cfg_mcast_en;
                    r_cfg_mac_addr <= cfg_mac_addr;
                end
                if (r_idx == 3'd5) r_last6 <= s_axis.tlast;
                r_idx <= (s_axis.tlast || r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            end
            if (r_state == REPLAY && m_axis.tready)
                r_ridx <= (r_ridx == 3'd5) ? 3'd0 : r_ridx + 3'd1;
            if (w_runt || w_reject) cnt_drop <= cnt_drop + 1'b1;
            if (w_rep_done)         cnt_accept <= cnt_accept + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HDR: begin
                if (w_eval)
                    w_state_nxt = w_accept ? REPLAY : (s_axis.tlast ? HDR : DROP);
            end
            REPLAY: if (w_rep_done) w_state_nxt = r_last6 ? HDR : PASS;
            PASS:   if (s_axis.tvalid && m_axis.tready && s_axis.tlast) w_state_nxt = HDR;
            DROP:   if (s_axis.tvalid && s_axis.tlast) w_state_nxt = HDR;
            default: w_state_nxt = HDR;
        endcase
    end

    always_comb begin
        s_axis.tready = 1'b0;
        m_axis.tvalid = 1'b0;
        m_axis.tdata  = '0;
        m_axis.tlast  = 1'b0;
        m_axis.tuser  = '0;
        if (!rst) begin
            case (r_state)
                HDR, DROP: s_axis.tready = 1'b1;
                REPLAY: begin
                    m_axis.tvalid = 1'b1;
                    m_axis.tdata  = r_hdr_data[r_ridx];
                    m_axis.tuser  = r_hdr_user[r_ridx];
                    m_axis.tlast  = r_last6 & (r_ridx == 3'd5);
                end
                PASS: begin
                    m_axis.tvalid = s_axis.tvalid;
                    s_axis.tready = m_axis.tready;
                    m_axis.tdata  = s_axis.tdata;
                    m_axis.tuser  = s_axis.tuser;
                    m_axis.tlast  = s_axis.tlast;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_taxi_eth_rx_dst_filter.sv
// Randomized frame-level bench for the rx destination filter with a queue model.
module tb_taxi_eth_rx_dst_filter;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    taxi_axis_if #(.DATA_W(8), .USER_W(1)) s_if ();
    taxi_axis_if #(.DATA_W(8), .USER_W(1)) m_if ();

    logic             cfg_enable, cfg_promisc, cfg_bcast_en, cfg_mcast_en;
    logic [47:0]      cfg_mac_addr;
    logic             stat_accept, stat_drop, stat_runt;
    logic [CNT_W-1:0] cnt_accept, cnt_drop;

    taxi_eth_rx_dst_filter #(.CNT_W(CNT_W), .USER_W(1)) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
        .cfg_enable(cfg_enable), .cfg_mac_addr(cfg_mac_addr), .cfg_promisc(cfg_promisc),
        .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
        .stat_accept(stat_accept), .stat_drop(stat_drop), .stat_runt(stat_runt),
        .cnt_accept(cnt_accept), .cnt_drop(cnt_drop)
    );

    typedef struct { logic [7:0] d; logic u; logic l; } beat_t;
    beat_t      exp_q[$];
    logic [7:0] fb[$];
    logic       fu[$];

    int vectors = 0, miscompares = 0;
    int m_acc = 0, m_drop = 0, m_runt = 0;
    int o_acc = 0, o_drop = 0, o_runt = 0;
    bit rdy_rand = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept rule stated frame-wise: a group address other than broadcast is multicast.
    function automatic bit mdl_accept(input logic [47:0] a, input bit en, input bit pr,
                                      input logic [47:0] mac, input bit bc, input bit mc);
        if (!en) return 0;
        if (pr) return 1;
        if (a == mac) return 1;
        if (a == 48'hFFFF_FFFF_FFFF) return bc;
        if (a[40]) return mc;
        return 0;
    endfunction

    task automatic build(input logic [47:0] da, input int len);
        fb.delete();
        fu.delete();
        for (int i = 0; i < len; i++) begin
            fb.push_back(i < 6 ? da[47 - 8*i -: 8] : 8'($urandom));
            fu.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // Entered and left just after a rising edge (or before a negedge with tvalid low).
    task automatic send_frame(input int chg_idx, input bit gaps);
        int n = fb.size();
        bit acc = 0, lat_pend = 0, v = 0, hs, held = 0;
        int i = 0, wd = 0;
        if (n < 6) m_runt++;
        else begin
            acc = mdl_accept({fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]}, cfg_enable,
                             cfg_promisc, cfg_mac_addr, cfg_bcast_en, cfg_mcast_en);
            if (acc) begin
                m_acc++;
                for (int k = 0; k < n; k++) exp_q.push_back('{d: fb[k], u: fu[k], l: (k == n-1)});
            end else m_drop++;
        end
        while (i < n) begin
            if (i == chg_idx) cfg_enable = 1'b0;
            v = held ? 1'b1 : !(gaps && $urandom_range(0, 3) == 0);
            s_if.tvalid = v;
            s_if.tdata  = fb[i];
            s_if.tuser  = fu[i];
            s_if.tlast  = (i == n-1);
            @(negedge clk);
            if (lat_pend) begin chk("first_out_latency", m_if.tvalid, 1); lat_pend = 0; end
            hs = v & s_if.tready;
            held = v & !hs;
            wd++;
            if (wd > 3000) begin chk("s_stall_timeout", 0, 1); break; end
            @(posedge clk); #1;
            if (hs) begin
                if (i == 5 && acc) lat_pend = 1;
                i++;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (lat_pend) begin @(negedge clk); chk("first_out_latency", m_if.tvalid, 1); end
    endtask

    task automatic drain();
        int wd = 0;
        while (exp_q.size() != 0 && wd < 3000) begin @(negedge clk); wd++; end
        if (exp_q.size() != 0) begin chk("drain_timeout", exp_q.size(), 0); exp_q.delete(); end
        repeat (3) @(negedge clk);
        chk("cnt_accept", cnt_accept, (m_acc) % (1 << CNT_W));
        chk("cnt_drop", cnt_drop, (m_drop + m_runt) % (1 << CNT_W));
        chk("pulses_accept", o_acc, m_acc);
        chk("pulses_drop", o_drop, m_drop);
        chk("pulses_runt", o_runt, m_runt);
        @(posedge clk); #1;
    endtask

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output compare against the expected-beat queue, plus AXI hold and pulse exclusivity.
    initial begin
        bit pv = 0, pr = 0;
        beat_t pb, e;
        forever begin
            @(negedge clk);
            if (rst) begin pv = 0; pr = 0; end
            else begin
                o_acc  += int'(stat_accept);
                o_drop += int'(stat_drop);
                o_runt += int'(stat_runt);
                if (stat_accept + stat_drop + stat_runt > 1)
                    chk("stat_onehot", {stat_accept, stat_drop, stat_runt}, 0);
                if (pv && !pr)
                    chk("axi_hold", {m_if.tvalid, m_if.tdata, m_if.tuser, m_if.tlast},
                        {1'b1, pb.d, pb.u, pb.l});
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", {m_if.tdata, m_if.tlast}, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {m_if.tdata, m_if.tuser, m_if.tlast}, {e.d, e.u, e.l});
                    end
                end
                pv = m_if.tvalid; pr = m_if.tready;
                pb = '{d: m_if.tdata, u: m_if.tuser, l: m_if.tlast};
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] da;
        int len;
        s_if.tvalid = 0; s_if.tdata = 0; s_if.tuser = 0; s_if.tlast = 0;
        cfg_enable = 1; cfg_mac_addr = 48'h02_00_00_00_00_01;
        cfg_promisc = 0; cfg_bcast_en = 0; cfg_mcast_en = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("post_rst_s_tready", s_if.tready, 1);
        chk("post_rst_m_tvalid", m_if.tvalid, 0);
        chk("post_rst_cnts", {cnt_accept, cnt_drop}, 0);
        chk("post_rst_stats", {stat_accept, stat_drop, stat_runt}, 0);
        chk("pin_ucast", mdl_accept(48'h02_00_00_00_00_01, 1, 0, cfg_mac_addr, 0, 0), 1);
        chk("pin_mcast_off", mdl_accept(48'h01_80_C2_00_00_01, 1, 0, cfg_mac_addr, 1, 0), 0);
        chk("pin_bcast_not_mcast", mdl_accept(48'hFFFF_FFFF_FFFF, 1, 0, cfg_mac_addr, 0, 1), 0);
        @(posedge clk); #1;

        build(cfg_mac_addr, 64); send_frame(-1, 0); drain();
        chk("ucast_cnt_accept_lit", cnt_accept, 1);

        cfg_bcast_en = 1;
        build(48'hFFFF_FFFF_FFFF, 64); send_frame(-1, 0); drain();
        chk("bcast_cnt_accept_lit", cnt_accept, 2);
        build(48'h01_80_C2_00_00_01, 64); send_frame(-1, 0); drain();
        chk("mcast_cnt_drop_lit", cnt_drop, 1);

        build(cfg_mac_addr, 4); send_frame(-1, 0); drain();
        chk("runt_pulse_lit", o_runt, 1);
        build(cfg_mac_addr, 64); send_frame(-1, 0); drain();

        cfg_promisc = 1;
        build(48'h0A_11_22_33_44_55, 6); send_frame(-1, 0); drain();
        cfg_promisc = 0;

        rdy_rand = 1;
        build(cfg_mac_addr, 100); send_frame(-1, 1); drain();

        build(cfg_mac_addr, 64); send_frame(20, 1); drain();
        chk("cfgchg_frame_passed_lit", cnt_accept, 6);
        build(cfg_mac_addr, 64); send_frame(-1, 1); drain();
        chk("cfgchg_next_dropped_lit", cnt_drop, 3);
        cfg_enable = 1;

        for (int f = 0; f < 80; f++) begin
            cfg_enable   = ($urandom_range(0, 9) != 0);
            cfg_promisc  = ($urandom_range(0, 5) == 0);
            cfg_bcast_en = 1'($urandom_range(0, 1));
            cfg_mcast_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) cfg_mac_addr = {$urandom, 16'($urandom)} & ~48'h0100_0000_0000;
            case ($urandom_range(0, 3))
                0: da = cfg_mac_addr;
                1: da = 48'hFFFF_FFFF_FFFF;
                2: da = {$urandom, 16'($urandom)} | 48'h0100_0000_0000;
                default: da = {$urandom, 16'($urandom)} & ~48'h0100_0000_0000;
            endcase
            case ($urandom_range(0, 4))
                0: len = $urandom_range(1, 5);
                1: len = $urandom_range(6, 8);
                default: len = $urandom_range(9, 70);
            endcase
            rdy_rand = 1'($urandom_range(0, 1));
            build(da, len);
            send_frame(-1, 1'($urandom_range(0, 1)));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
